vx_skid_buffer: RTL and testbench
=================================

# vx_skid_buffer

Two-entry elastic buffer on the valid/ready stream interface. Both `ready_in` and `data_out` are fully registered, so no combinational path exists from `ready_out` to `ready_in` or from `data_in` to `data_out`. It breaks the backpressure timing path where a single-register pipe stage would leave `ready_in` coupled to `ready_out`. It sits between pipeline stages at long-route or cross-cluster boundaries and sustains one transfer per cycle.

## Interface
- `DATAW`, 1, payload width in bits (≥1)
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous discard of all buffered entries
- `valid_in`  in  1  upstream offers `data_in`
- `ready_in`  out  1  buffer accepts; registered
- `data_in`  in  DATAW  upstream payload
- `valid_out`  out  1  `data_out` holds a valid entry; registered
- `ready_out`  in  1  downstream accepts
- `data_out`  out  DATAW  head payload; registered
- `perf_stalls`  out  32  stall-cycle count; present only with `VX_SKID_BUFFER_PERF_EN`

## Operation
- Push = `valid_in && ready_in`. Pop = `valid_out && ready_out`.
- Storage: main register (drives `data_out`) and skid register. State is EMPTY, ONE (main valid) or FULL (main and skid valid).
- EMPTY: push → main ← `data_in`, go to ONE.
- ONE:
  - push & pop → main ← `data_in`, stay in ONE.
  - push & no pop → skid ← `data_in`, go to FULL.
  - pop & no push → go to EMPTY.
- FULL: `ready_in`=0, so no push. Pop → main ← skid, go to ONE.
- `valid_out` = (state ≠ EMPTY). `ready_in` = registered (next state ≠ FULL).
- Ordering is strict FIFO. No entry is dropped or duplicated.
- `data_out` holds its last value while `valid_out`=0. Downstream must not sample it then.
- `flush`: next state is EMPTY and `ready_in` becomes 1. Flush takes priority over push and pop in the same cycle: the pushed beat is discarded and no pop is counted. The upstream handshake still completes, so the producer sees it as accepted.
- `reset` overrides `flush`.

## Timing
- Reset values: `valid_out`=0, `ready_in`=0, `data_out`=0, state EMPTY, `perf_stalls`=0.
- `ready_in` rises on the first edge where `reset`=0, i.e. one cycle after reset deasserts. While `reset` is high, `valid_in` is ignored.
- Latency: a push at edge N gives `valid_out`=1 with that data after edge N (1 cycle).
- Throughput: 1 beat/cycle sustained while `ready_out`=1.
- Backpressure:
  - `ready_in` falls one cycle after the first un-popped push following a push.
  - Exactly one extra beat is absorbed by the skid register.
  - `ready_in` returns to 1 the cycle after a pop from FULL.
- `valid_out` never deasserts without a pop, flush or reset. `data_out` is stable while `valid_out && !ready_out`.

## Configuration
- `VX_SKID_BUFFER_PERF_EN` defined:
  - Adds `perf_stalls`, a 32-bit counter incremented each cycle with `valid_out && !ready_out`.
  - It saturates at 0xFFFF_FFFF.
  - It is cleared by `reset` only; `flush` does not clear it.
- Not defined: the port and counter are absent. Datapath behaviour is identical.

## Test plan
- Reset and streaming:
  - Stimulus: hold `reset` for 3 cycles, then `valid_in`=1 with `data_in`=0x1,0x2,0x3… and `ready_out`=1.
  - Required: `ready_in`=0 during reset and 1 from the first cycle after. `data_out` sequence is 0x1,0x2,… with one beat per cycle and a 1-cycle lag.
- Backpressure skid:
  - Stimulus: stream 0xA,0xB,0xC with `ready_out`=0 from the cycle 0xA appears on `data_out`.
  - Required: 0xA is held on `data_out`, 0xB is captured in the skid register, and `ready_in`=0 the next cycle. 0xC is held upstream.
  - Release `ready_out` → output 0xA,0xB,0xC in order with no gaps.
- Drain to empty:
  - Stimulus: a single push of 0x5 followed by a pop.
  - Required: `valid_out`=1 for exactly one cycle, then 0. `data_out` stays 0x5 after.
- Flush while FULL, with push attempted the same cycle:
  - Required: next cycle `valid_out`=0 and `ready_in`=1. Neither buffered beat nor the pushed beat ever appears.
- Random valid/ready with a scoreboard (10k cycles, DATAW=32):
  - Required: output order equals input order. `ready_in` is never 0 while state is EMPTY or ONE after a cycle without a push.
- With `VX_SKID_BUFFER_PERF_EN`: hold `ready_out`=0 for 7 cycles with `valid_out`=1 → `perf_stalls`=7. Preload 0xFFFF_FFFE and stall 3 cycles → it reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/vx_skid_buffer.sv
// vx_skid_buffer: two-entry elastic buffer; ready_in and data_out are both registered.
// Latency: 1 cycle from push to valid_out; sustains one beat per cycle.
// Backpressure: one extra beat lands in the skid register, then ready_in drops. Optional stall counter under VX_SKID_BUFFER_PERF_EN.

module vx_skid_buffer #(
  parameter int DATAW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [DATAW-1:0] data_out
`ifdef VX_SKID_BUFFER_PERF_EN
  ,
  output logic [31:0]      perf_stalls
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [DATAW-1:0] skid_dat;
  logic             push;
  logic             pop;

  assign push = valid_in && ready_in;
  assign pop  = valid_out && ready_out;

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (push) state_n = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_n = ST_FULL;
          else if (!push && pop) state_n = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_n = ST_ONE;
        default:  state_n = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs are flops loaded from the next state, so ready_out never reaches ready_in combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_EMPTY;
      valid_out <= 1'b0;
      ready_in  <= 1'b0;
      data_out  <= '0;
      skid_dat  <= '0;
    end else begin
      state     <= state_n;
      valid_out <= (state_n != ST_EMPTY);
      ready_in  <= (state_n != ST_FULL);
      if (!flush) begin
        case (state)
          ST_EMPTY: if (push) data_out <= data_in;
          ST_ONE: begin
            if (push && pop)       data_out <= data_in;
            else if (push && !pop) skid_dat <= data_in;
          end
          ST_FULL:  if (pop) data_out <= skid_dat;
          default: ;
        endcase
      end
    end
  end

`ifdef VX_SKID_BUFFER_PERF_EN
  // Saturating; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls <= '0;
    end else if (valid_out && !ready_out && (perf_stalls != 32'hFFFF_FFFF)) begin
      perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_skid_buffer.sv
// Directed and scoreboarded bench for vx_skid_buffer with DATAW=32.
// Inputs are driven and outputs sampled 1ns after each rising edge.

module tb_vx_skid_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] data_in;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] data_out;
`ifdef VX_SKID_BUFFER_PERF_EN
  logic [31:0] perf_stalls;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  vx_skid_buffer #(.DATAW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out)
`ifdef VX_SKID_BUFFER_PERF_EN
    ,
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic        exp_rdy;
  logic        vi, ro, fl;

  initial begin
    // Reset: valid_in is offered but must be ignored.
    reset = 1'b1; flush = 1'b0; valid_in = 1'b1; data_in = 32'h99; ready_out = 1'b0;
    repeat (3) begin
      step();
      chk("rst_rdy", ready_in, 32'd0);
    end
    chk("rst_vld", valid_out, 32'd0);
    chk("rst_dat", data_out, 32'd0);

    // Streaming: first edge out of reset only raises ready_in.
    reset = 1'b0; valid_in = 1'b1; data_in = 32'h1; ready_out = 1'b1;
    step();
    chk("str_rdy_rise", ready_in, 32'd1);
    chk("str_vld_first", valid_out, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("str_vld", valid_out, 32'd1);
      chk("str_dat", data_out, i);
      chk("str_rdy", ready_in, 32'd1);
      data_in = i + 1;
    end
    valid_in = 1'b0;
    step();
    chk("str_drain", valid_out, 32'd0);

    // Backpressure skid.
    ready_out = 1'b0; valid_in = 1'b1; data_in = 32'hA;
    step();
    chk("skid_a_dat", data_out, 32'hA);
    chk("skid_a_rdy", ready_in, 32'd1);
    data_in = 32'hB;
    step();
    chk("skid_b_hold", data_out, 32'hA);
    chk("skid_b_rdy", ready_in, 32'd0);
    data_in = 32'hC;
    step();
    chk("skid_c_hold", data_out, 32'hA);
    chk("skid_c_vld", valid_out, 32'd1);
    chk("skid_c_rdy", ready_in, 32'd0);
    ready_out = 1'b1;
    step();
    chk("skid_out_b", data_out, 32'hB);
    chk("skid_rdy_back", ready_in, 32'd1);
    step();
    chk("skid_out_c", data_out, 32'hC);
    chk("skid_out_c_vld", valid_out, 32'd1);
    valid_in = 1'b0;
    step();
    chk("skid_empty", valid_out, 32'd0);

    // Drain to empty.
    valid_in = 1'b1; data_in = 32'h5; ready_out = 1'b1;
    step();
    chk("drn_vld", valid_out, 32'd1);
    chk("drn_dat", data_out, 32'h5);
    valid_in = 1'b0;
    step();
    chk("drn_vld_off", valid_out, 32'd0);
    chk("drn_dat_hold", data_out, 32'h5);
    step();
    chk("drn_dat_hold2", data_out, 32'h5);

    // Flush while FULL with a push offered.
    ready_out = 1'b0; valid_in = 1'b1; data_in = 32'h11;
    step();
    data_in = 32'h22;
    step();
    chk("fl_full_rdy", ready_in, 32'd0);
    flush = 1'b1; data_in = 32'h33; ready_out = 1'b1;
    step();
    chk("fl_vld", valid_out, 32'd0);
    chk("fl_rdy", ready_in, 32'd1);
    flush = 1'b0; valid_in = 1'b0;
    step();
    chk("fl_stay_empty", valid_out, 32'd0);

    // Flush in ONE with a real handshake: the pushed beat is dropped.
    valid_in = 1'b1; data_in = 32'h44; ready_out = 1'b0;
    step();
    flush = 1'b1; data_in = 32'h55; ready_out = 1'b1;
    step();
    chk("fl1_vld", valid_out, 32'd0);
    chk("fl1_rdy", ready_in, 32'd1);
    flush = 1'b0; data_in = 32'h66;
    step();
    chk("fl1_next_dat", data_out, 32'h66);
    valid_in = 1'b0;
    step();
    chk("fl1_empty", valid_out, 32'd0);

    // Random valid/ready with occasional flush against a queue model.
    q.delete();
    exp_rdy = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      vi = ($urandom_range(0, 3) != 0);
      ro = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 255) == 0);
      valid_in = vi; data_in = $urandom; ready_out = ro; flush = fl;
      chk("rnd_rdy", ready_in, exp_rdy);
      chk("rnd_vld", valid_out, (q.size() != 0));
      if (q.size() != 0) chk("rnd_dat", data_out, q[0]);
      if (fl) begin
        q.delete();
      end else begin
        if (ro && q.size() != 0) void'(q.pop_front());
        if (vi && exp_rdy) q.push_back(data_in);
      end
      exp_rdy = (q.size() < 2);
      step();
    end
    flush = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    repeat (3) step();
    chk("rnd_drained", valid_out, 32'd0);

`ifdef VX_SKID_BUFFER_PERF_EN
    reset = 1'b1;
    step();
    reset = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
    step();
    chk("perf_rst", perf_stalls, 32'd0);
    valid_in = 1'b1; data_in = 32'h7;
    step();
    valid_in = 1'b0;
    repeat (7) step();
    chk("perf_7", perf_stalls, 32'd7);
    force dut.perf_stalls = 32'hFFFF_FFFE;
    #1;
    release dut.perf_stalls;
    repeat (3) step();
    chk("perf_sat", perf_stalls, 32'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
